pipe_skid_stage: RTL and testbench
==================================

// Module: pipe_skid_stage
// PURPOSE
// - Parametrised inter-stage pipeline register with valid/ready handshake, replacing the bare stall-gated F/D, D/E, E/M, M/W latches.
// - Optional 2-entry skid buffer: in_ready is registered, so upstream never sees a combinational path from downstream ready.
// - Adds flush (branch/exception squash) and an occupancy count; payload is an opaque vector (e.g. $bits(fetch_data_t)).
// PARAMETERS
// - WIDTH      default 160    payload width in bits
// - SKID       default 1      1: two-entry skid buffer, registered in_ready; 0: single entry, combinational in_ready
// - RESET_VAL  default '0     reset value of out_data (F/D instance: pc field = 64'h8000_0000, rest 0)
// PORTS
// - clk        in   1      clock, all state on rising edge
// - reset      in   1      asynchronous, active-low (0 = in reset); deassertion synchronised externally
// - flush      in   1      squash all held entries
// - in_valid   in   1      upstream payload valid
// - in_ready   out  1      stage can accept this cycle
// - in_data    in   WIDTH  upstream payload
// - out_valid  out  1      out_data holds a live entry
// - out_ready  in   1      downstream accepts this cycle
// - out_data   out  WIDTH  oldest held payload
// - count      out  2      entries held (0..2; 0..1 when SKID=0)
// BEHAVIOUR
// - Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Data moves only on fire.
// - Reset (reset=0, async): count=0, out_valid=0, out_data=RESET_VAL, skid reg='0, in_ready=1. Reset mid-transfer discards all entries.
// - SKID=1 states (enum): EMPTY(count 0), ONE(main valid), FULL(main+skid valid); in_ready = (state!=FULL), a register output.
// -   EMPTY: in_fire -> ONE, main<=in_data.
// -   ONE: in_fire&out_fire -> ONE, main<=in_data; in_fire&!out_fire -> FULL, skid<=in_data; !in_fire&out_fire -> EMPTY.
// -   FULL: no input accepted; out_fire -> ONE, main<=skid; else hold.
// - SKID=0: single entry; in_ready = !out_valid | out_ready (combinational); in_fire loads main, out_fire without in_fire empties.
// - Latency: 1 cycle in->out when empty; throughput 1/cycle with out_ready held high; FIFO order always preserved.
// - flush: next state EMPTY, count=0; overrides a simultaneous in_fire (payload dropped). A same-cycle out_fire is still a valid transfer.
// - flush while FULL: both entries dropped; in_ready=1 next cycle.
// - out_data/skid hold last value when not loaded (no clear on empty/flush); consumers must qualify with out_valid.
// - out_valid = (count!=0); count==2 only when SKID=1.
// - in_valid may drop without fire; out_valid, once high, stays high with stable out_data until out_fire or flush.
// STRUCTURE
// - pipes package: typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_FULL} pipe_state_e; localparam PC_RESET = 64'h8000_0000.
// - Stage payload typedefs (fetch_data_t, decode_data_t, ...) stay in pipes; instances pass $bits() as WIDTH.
// - No sub-module: SKID=0/1 are two generate branches in one module; one instance per stage boundary.
// TESTING
// - Reset: hold reset=0 3 cycles with in_valid=1 -> out_valid=0, count=0, out_data=RESET_VAL, in_ready=1; release -> first fire accepted.
// - Streaming: out_ready=1, push 0x11,0x22,0x33 back-to-back -> out_data 0x11,0x22,0x33 on consecutive cycles, count stays 1.
// - Backpressure (SKID=1): out_ready=0, push 0xA,0xB,0xC -> 0xA,0xB held, count=2, in_ready=0, 0xC held upstream; out_ready=1 -> 0xA,0xB,0xC in order.
// - Flush with simultaneous push while FULL -> next cycle count=0, out_valid=0, pushed payload never appears.
// - SKID=0: out_ready=0 with entry held -> in_ready=0 same cycle; out_ready=1 & in_valid -> replace in one cycle, count stays 1.
// - Async reset asserted mid-cycle while FULL -> outputs reach reset values before next clk edge.

Source files
------------

// File: rtl/pipes_pkg.sv
// +----------------------------------------------------------------------------+
// | pipes: shared pipeline types and constants for inter-stage registers       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package pipes;

  // Encodings equal the number of held entries, so state doubles as count.
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

  localparam logic [63:0] PC_RESET = 64'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/pipe_skid_stage.sv
// +----------------------------------------------------------------------------+
// | pipe_skid_stage: valid/ready pipeline register, optional 2-entry skid      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module pipe_skid_stage
  import pipes::*;
#(
  parameter int               WIDTH     = 160,
  parameter bit               SKID      = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  generate
    if (SKID) begin : g_skid
      pipe_state_e      r_state;
      pipe_state_e      w_state_nxt;
      logic [WIDTH-1:0] r_main;
      logic [WIDTH-1:0] r_skid;
      logic             r_in_ready;
      logic             w_in_fire;
      logic             w_out_fire;
      logic             w_load_main_in;
      logic             w_load_main_skid;
      logic             w_load_skid;

      always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        w_in_fire        = in_valid & r_in_ready;
        w_out_fire       = (r_state != PS_EMPTY) & out_ready;
        case (r_state)
          PS_EMPTY: begin
            if (w_in_fire) begin
              w_state_nxt    = PS_ONE;
              w_load_main_in = 1'b1;
            end
          end
          PS_ONE: begin
            if (w_in_fire && w_out_fire) begin
              w_load_main_in = 1'b1;
            end else if (w_in_fire) begin
              w_state_nxt = PS_FULL;
              w_load_skid = 1'b1;
            end else if (w_out_fire) begin
              w_state_nxt = PS_EMPTY;
            end
          end
          PS_FULL: begin
            if (w_out_fire) begin
              w_state_nxt      = PS_ONE;
              w_load_main_skid = 1'b1;
            end
          end
          default: w_state_nxt = PS_EMPTY;
        endcase
        // Squash wins over any accepted input; storage is simply left as-is.
        if (flush) begin
          w_state_nxt      = PS_EMPTY;
          w_load_main_in   = 1'b0;
          w_load_main_skid = 1'b0;
          w_load_skid      = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_state    <= PS_EMPTY;
          r_in_ready <= 1'b1;
        end else begin
          r_state    <= w_state_nxt;
          r_in_ready <= (w_state_nxt != PS_FULL);
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_main <= RESET_VAL;
          r_skid <= '0;
        end else begin
          if (w_load_main_in) begin
            r_main <= in_data;
          end else if (w_load_main_skid) begin
            r_main <= r_skid;
          end
          if (w_load_skid) begin
            r_skid <= in_data;
          end
        end
      end

      assign in_ready  = r_in_ready;
      assign out_valid = (r_state != PS_EMPTY);
      assign out_data  = r_main;
      assign count     = r_state;
    end else begin : g_single
      logic             r_valid;
      logic [WIDTH-1:0] r_main;
      logic             w_in_ready;
      logic             w_in_fire;
      logic             w_out_fire;

      assign w_in_ready = ~r_valid | out_ready;
      assign w_in_fire  = in_valid & w_in_ready;
      assign w_out_fire = r_valid & out_ready;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_valid <= 1'b0;
          r_main  <= RESET_VAL;
        end else if (flush) begin
          r_valid <= 1'b0;
        end else if (w_in_fire) begin
          r_valid <= 1'b1;
          r_main  <= in_data;
        end else if (w_out_fire) begin
          r_valid <= 1'b0;
        end
      end

      assign in_ready  = w_in_ready;
      assign out_valid = r_valid;
      assign out_data  = r_main;
      assign count     = {1'b0, r_valid};
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
// +----------------------------------------------------------------------------+
// | tb_pipe_skid_stage: SKID=1 and SKID=0 stages against a queue model         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_pipe_skid_stage;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;

  logic         in_ready1, out_valid1;
  logic [W-1:0] out_data1;
  logic [1:0]   count1;
  logic         in_ready0, out_valid0;
  logic [W-1:0] out_data0;
  logic [1:0]   count0;

  pipe_skid_stage #(.WIDTH(W), .SKID(1'b1), .RESET_VAL(RV)) dut_skid (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .count(count1)
  );

  pipe_skid_stage #(.WIDTH(W), .SKID(1'b0), .RESET_VAL(RV)) dut_single (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .count(count0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // FIFO model: q1 holds up to 2 entries, q0 up to 1; shown* is the value
  // out_data must present (front entry, or the last one shown once empty).
  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];
  logic [W-1:0] shown1, shown0;

  task automatic model_clear();
    q1.delete();
    q0.delete();
    shown1 = RV;
    shown0 = RV;
  endtask

  task automatic model_step();
    bit ir1, ir0, of1, of0;
    ir1 = (q1.size() < 2);
    ir0 = (q0.size() == 0) || out_ready;
    of1 = (q1.size() != 0) && out_ready;
    of0 = (q0.size() != 0) && out_ready;
    if (of1) void'(q1.pop_front());
    if (of0) void'(q0.pop_front());
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (in_valid && ir1) q1.push_back(in_data);
      if (in_valid && ir0) q0.push_back(in_data);
    end
    if (q1.size() != 0) shown1 = q1[0];
    if (q0.size() != 0) shown0 = q0[0];
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    else model_clear();
    #1;
  endtask

  // Compare every cycle, half a period after the edge.
  initial begin
    forever begin
      @(negedge clk);
      check("s1_count",     {30'd0, count1},    q1.size());
      check("s1_out_valid", {31'd0, out_valid1}, {31'd0, q1.size() != 0});
      check("s1_out_data",  {24'd0, out_data1}, {24'd0, shown1});
      check("s1_in_ready",  {31'd0, in_ready1}, {31'd0, q1.size() < 2});
      check("s0_count",     {30'd0, count0},    q0.size());
      check("s0_out_valid", {31'd0, out_valid0}, {31'd0, q0.size() != 0});
      check("s0_out_data",  {24'd0, out_data0}, {24'd0, shown0});
      check("s0_in_ready",  {31'd0, in_ready0},
            {31'd0, (q0.size() == 0) || out_ready});
    end
  end

  initial begin
    model_clear();
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h99;
    out_ready = 1'b1;

    repeat (3) tick();
    check("rst_s1_out_valid", {31'd0, out_valid1}, 32'd0);
    check("rst_s1_count",     {30'd0, count1},     32'd0);
    check("rst_s1_out_data",  {24'd0, out_data1},  32'hA5);
    check("rst_s1_in_ready",  {31'd0, in_ready1},  32'd1);
    check("rst_s0_out_data",  {24'd0, out_data0},  32'hA5);

    // Streaming at full rate
    reset = 1'b1;
    in_data = 8'h11; tick();
    check("stream_11", {24'd0, out_data1}, 32'h11);
    check("stream_cnt_a", {30'd0, count1}, 32'd1);
    in_data = 8'h22; tick();
    check("stream_22", {24'd0, out_data1}, 32'h22);
    check("stream_s0_22", {24'd0, out_data0}, 32'h22);
    in_data = 8'h33; tick();
    check("stream_33", {24'd0, out_data1}, 32'h33);
    check("stream_cnt_c", {30'd0, count1}, 32'd1);
    in_valid = 1'b0; tick();
    check("stream_drained", {31'd0, out_valid1}, 32'd0);

    // Backpressure: skid fills, single-entry stage stalls immediately
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h0A; tick();
    in_data = 8'h0B; tick();
    check("bp_s1_count",    {30'd0, count1},    32'd2);
    check("bp_s1_in_ready", {31'd0, in_ready1}, 32'd0);
    check("bp_s1_head",     {24'd0, out_data1}, 32'h0A);
    check("bp_s0_in_ready", {31'd0, in_ready0}, 32'd0);
    check("bp_s0_head",     {24'd0, out_data0}, 32'h0A);
    in_data = 8'h0C; tick();
    check("bp_s1_hold",     {24'd0, out_data1}, 32'h0A);
    out_ready = 1'b1; tick();
    check("bp_s1_second",   {24'd0, out_data1}, 32'h0B);
    check("bp_s1_cnt1",     {30'd0, count1},    32'd1);
    check("s0_replace",     {24'd0, out_data0}, 32'h0C);
    check("s0_replace_cnt", {30'd0, count0},    32'd1);
    tick();
    check("bp_s1_third",    {24'd0, out_data1}, 32'h0C);
    in_valid = 1'b0;
    repeat (2) tick();

    // Flush while FULL with a push pending
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'hD1; tick();
    in_data = 8'hD2; tick();
    in_data = 8'hD3; flush = 1'b1; tick();
    check("fl_full_count",    {30'd0, count1},     32'd0);
    check("fl_full_valid",    {31'd0, out_valid1}, 32'd0);
    check("fl_full_in_ready", {31'd0, in_ready1},  32'd1);
    check("fl_full_hold",     {24'd0, out_data1},  32'hD1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) tick();

    // Flush drops an accepted push in ONE; then flush with out_fire
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'hE1; tick();
    in_data = 8'hE2; flush = 1'b1; tick();
    check("fl_one_count", {30'd0, count1}, 32'd0);
    check("fl_one_hold",  {24'd0, out_data1}, 32'hE1);
    flush = 1'b0; in_data = 8'hE3; tick();
    out_ready = 1'b1; flush = 1'b1; in_data = 8'hE4; tick();
    check("fl_ofire_s0", {31'd0, out_valid0}, 32'd0);
    flush = 1'b0; in_valid = 1'b0; tick();

    // Asynchronous reset mid-cycle while FULL
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'hF1; tick();
    in_data = 8'hF2; tick();
    check("ar_full", {30'd0, count1}, 32'd2);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    model_clear();
    #1;
    check("ar_count",    {30'd0, count1},     32'd0);
    check("ar_valid",    {31'd0, out_valid1}, 32'd0);
    check("ar_in_ready", {31'd0, in_ready1},  32'd1);
    check("ar_data",     {24'd0, out_data1},  32'hA5);
    check("ar_s0_data",  {24'd0, out_data0},  32'hA5);
    tick();
    reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h5C; tick();
    check("ar_after", {24'd0, out_data1}, 32'h5C);
    in_valid = 1'b0;
    repeat (2) tick();

    // Random tail against the model
    for (int i = 0; i < 200; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = 8'($urandom);
      tick();
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
